// File: rtl/silar_receiver.sv
// silar_receiver: recovers 8-bit pixels from the 14-bit SILAR word stream.
// Each pixel arrives as two half-words (low half first). The block pairs the
// halves, checks per-word parity, tracks frame/line structure from the
// embedded Vsync/Hsync bits, and reports framing and parity errors.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   data_i[13:0]        SILAR word: [11]=Vsync [10]=Hsync [9]=low-half select
//                       [8]=parity [7:0]=payload ([13:12] unused)
//   pix_o, pix_valid_o  reassembled pixel and its one-cycle strobe
//   sof_o, eol_o        first pixel of frame / last active pixel of line
//   line_o, col_o       position of the emitted pixel (saturate at 1023)
//   parity_err_o        pulse on a parity mismatch of an active word
//   sync_err_o          pulse on a half-word pairing violation
//   line_len_err_o      pulse when a line ends with col count != VALID_PIX
//   frame_len_err_o     pulse when a frame ends with line count != VALID_LINES
//   parity_err_cnt_o    saturating parity-error count
//   locked_o            set by the first Vsync fall after reset
module silar_receiver #(
    parameter int VALID_PIX   = 640,
    parameter int VALID_LINES = 480,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [13:0]          data_i,
    output logic [7:0]           pix_o,
    output logic                 pix_valid_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic [9:0]           line_o,
    output logic [9:0]           col_o,
    output logic                 parity_err_o,
    output logic                 sync_err_o,
    output logic                 line_len_err_o,
    output logic                 frame_len_err_o,
    output logic [ERR_CNT_W-1:0] parity_err_cnt_o,
    output logic                 locked_o
);

    localparam logic [9:0]  PIX_END   = 10'(VALID_PIX);
    localparam logic [9:0]  LAST_COL  = 10'(VALID_PIX - 1);
    localparam logic [10:0] LINES_END = 11'(VALID_LINES);

    typedef enum logic [2:0] {IDLE, VBLANK, HBLANK, ACT_LO, ACT_HI} state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    state_t      state;
    logic [11:0] d_p0;
    logic        vs_p1, hs_p1;
    logic [1:0]  lo_bits;
    logic [9:0]  line_cnt, col_cnt;
    logic        first_pix;

    logic unused_bits;
    assign unused_bits = ^data_i[13:12];

    // Stage 0: input register plus previous sync bits for edge detection
    always_ff @(posedge clk_i) begin
        d_p0  <= data_i[11:0];
        vs_p1 <= d_p0[11];
        hs_p1 <= d_p0[10];
    end

    logic        vs, hs, vs_rise, vs_fall, hs_rise, hs_fall;
    logic        half_lo, par_ok, in_act, enter_act, take_word;
    logic        frame_end, line_end;
    logic [10:0] frame_lines;

    assign vs        = d_p0[11];
    assign hs        = d_p0[10];
    assign half_lo   = d_p0[9];
    assign par_ok    = (d_p0[8] == ^d_p0[7:0]);
    assign vs_rise   = vs & ~vs_p1;
    assign vs_fall   = ~vs & vs_p1;
    assign hs_rise   = hs & ~hs_p1;
    assign hs_fall   = ~hs & hs_p1;
    assign in_act    = (state == ACT_LO) || (state == ACT_HI);
    // The word that drops Hsync is already the first low half of the line.
    assign enter_act = (state == HBLANK) && hs_fall && !vs;
    assign take_word = !vs && !hs && (in_act || enter_act);
    assign frame_end = vs_rise && (state != IDLE);
    assign line_end  = hs_rise && in_act;
    // A line closed by the same word that raises Vsync still counts toward the frame.
    assign frame_lines = {1'b0, line_cnt} + {10'd0, line_end};

    // Stage 1: frame/line FSM and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            locked_o         <= 1'b0;
            line_cnt         <= '0;
            col_cnt          <= '0;
            first_pix        <= 1'b0;
            pix_valid_o      <= 1'b0;
            pix_o            <= '0;
            sof_o            <= 1'b0;
            eol_o            <= 1'b0;
            line_o           <= '0;
            col_o            <= '0;
            parity_err_o     <= 1'b0;
            sync_err_o       <= 1'b0;
            line_len_err_o   <= 1'b0;
            frame_len_err_o  <= 1'b0;
            parity_err_cnt_o <= '0;
        end else begin
            pix_valid_o     <= 1'b0;
            sof_o           <= 1'b0;
            eol_o           <= 1'b0;
            parity_err_o    <= 1'b0;
            sync_err_o      <= 1'b0;
            line_len_err_o  <= 1'b0;
            frame_len_err_o <= 1'b0;

            if (take_word && !par_ok) begin
                parity_err_o     <= 1'b1;
                parity_err_cnt_o <= sat_inc_err(parity_err_cnt_o);
            end

            if (frame_end) begin
                state           <= VBLANK;
                frame_len_err_o <= (frame_lines != LINES_END);
                if (line_end) begin
                    line_len_err_o <= (col_cnt != PIX_END);
                    sync_err_o     <= (state == ACT_HI);
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (vs) state <= VBLANK;
                    end
                    VBLANK: begin
                        if (vs_fall) begin
                            locked_o  <= 1'b1;
                            line_cnt  <= '0;
                            first_pix <= 1'b1;
                            state     <= HBLANK;
                        end
                    end
                    HBLANK: begin
                        if (enter_act) begin
                            col_cnt <= '0;
                            if (half_lo) begin
                                lo_bits <= d_p0[7:6];
                                state   <= ACT_HI;
                            end else begin
                                sync_err_o <= 1'b1;
                                state      <= ACT_LO;
                            end
                        end
                    end
                    ACT_LO, ACT_HI: begin
                        if (line_end) begin
                            line_cnt       <= sat_inc10(line_cnt);
                            line_len_err_o <= (col_cnt != PIX_END);
                            sync_err_o     <= (state == ACT_HI);
                            state          <= HBLANK;
                        end else if (take_word) begin
                            if (state == ACT_LO) begin
                                if (half_lo) begin
                                    lo_bits <= d_p0[7:6];
                                    state   <= ACT_HI;
                                end else begin
                                    sync_err_o <= 1'b1;
                                end
                            end else if (!half_lo) begin
                                pix_valid_o <= 1'b1;
                                pix_o       <= {d_p0[5:0], lo_bits};
                                sof_o       <= first_pix;
                                eol_o       <= (col_cnt == LAST_COL);
                                line_o      <= line_cnt;
                                col_o       <= col_cnt;
                                first_pix   <= 1'b0;
                                col_cnt     <= sat_inc10(col_cnt);
                                state       <= ACT_LO;
                            end else begin
                                // Repeated low half: the newer one wins.
                                sync_err_o <= 1'b1;
                                lo_bits    <= d_p0[7:6];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_silar_receiver.sv
module tb_silar_receiver;
    localparam int VP = 4;
    localparam int VL = 3;
    localparam int EW = 4;
    localparam logic [13:0] VB = 14'hC00;
    localparam logic [13:0] HB = 14'h400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [13:0]   data = 14'h000;
    logic [7:0]    pix_o;
    logic          pix_valid_o, sof_o, eol_o;
    logic [9:0]    line_o, col_o;
    logic          parity_err_o, sync_err_o, line_len_err_o, frame_len_err_o;
    logic [EW-1:0] parity_err_cnt_o;
    logic          locked_o;

    silar_receiver #(.VALID_PIX(VP), .VALID_LINES(VL), .ERR_CNT_W(EW)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data),
        .pix_o(pix_o), .pix_valid_o(pix_valid_o), .sof_o(sof_o), .eol_o(eol_o),
        .line_o(line_o), .col_o(col_o),
        .parity_err_o(parity_err_o), .sync_err_o(sync_err_o),
        .line_len_err_o(line_len_err_o), .frame_len_err_o(frame_len_err_o),
        .parity_err_cnt_o(parity_err_cnt_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic [9:0] line;
        logic [9:0] col;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int c_par = 0, c_sync = 0, c_llen = 0, c_flen = 0;
    int e_par = 0, e_sync = 0, e_llen = 0, e_flen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every pixel strobe, counts error pulses.
    always @(negedge clk) begin
        exp_t e;
        if (pix_valid_o) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel got pix=%02h line=%0d col=%0d required no pixel",
                         pix_o, line_o, col_o);
            end else begin
                e = q.pop_front();
                check($sformatf("pixel_l%0d_c%0d", e.line, e.col),
                      {2'b00, pix_o, sof_o, eol_o, line_o, col_o}, {2'b00, e});
            end
        end
        c_par  += int'(parity_err_o);
        c_sync += int'(sync_err_o);
        c_llen += int'(line_len_err_o);
        c_flen += int'(frame_len_err_o);
    end

    function automatic logic [13:0] w_lo(input logic [7:0] p, input logic bad);
        logic [7:0] pl;
        pl = {p[1:0], 6'b000000};
        return {4'b0000, 1'b1, (^pl) ^ bad, pl};
    endfunction

    function automatic logic [13:0] w_hi(input logic [7:0] p);
        logic [7:0] pl;
        pl = {2'b00, p[7:2]};
        return {4'b0000, 1'b0, ^pl, pl};
    endfunction

    function automatic logic [7:0] pv(input int l, input int c);
        return 8'(60 + l * 41 + c * 23);
    endfunction

    task automatic send(input logic [13:0] w);
        @(negedge clk);
        data = w;
    endtask

    task automatic expect_pix(input logic [7:0] p, input int l, input int c, input logic sof);
        exp_t e;
        e.pix  = p;
        e.sof  = sof;
        e.eol  = (c == VP - 1);
        e.line = 10'(l);
        e.col  = 10'(c);
        q.push_back(e);
    endtask

    task automatic pix(input logic [7:0] p, input int l, input int c, input logic sof, input logic bad);
        send(w_lo(p, bad));
        send(w_hi(p));
        expect_pix(p, l, c, sof);
    endtask

    task automatic line_px(input int l, input int n, input logic first, input logic bad);
        for (int c = 0; c < n; c++) pix(pv(l, c), l, c, first && (c == 0), bad);
    endtask

    task automatic gap();
        send(HB);
        send(HB);
    endtask

    task automatic frame_start();
        send(VB);
        send(HB);
        send(HB);
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        #2;
        check({tag, "_queue_left"}, q.size(), 0);
        check({tag, "_parity_pulses"}, c_par, e_par);
        check({tag, "_sync_pulses"}, c_sync, e_sync);
        check({tag, "_line_len_pulses"}, c_llen, e_llen);
        check({tag, "_frame_len_pulses"}, c_flen, e_flen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got running required finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {pix_valid_o, sof_o, eol_o, parity_err_o, sync_err_o, line_len_err_o,
               frame_len_err_o, locked_o, pix_o, line_o, col_o}, 0);
        check("reset_err_cnt", parity_err_cnt_o, 0);
        rst = 1'b0;

        // Words before any Vsync are ignored
        send(14'h340); send(14'h02D); send(14'h340); send(14'h02D); send(HB);
        drain("prelock");
        check("prelock_locked", locked_o, 0);

        // Frame A: clean frame, first pixel 0xB5 from raw words
        frame_start();
        send(14'h340); send(14'h02D); expect_pix(8'hB5, 0, 0, 1'b1);
        for (int c = 1; c < VP; c++) pix(pv(0, c), 0, c, 1'b0, 1'b0);
        gap(); line_px(1, VP, 1'b0, 1'b0);
        gap(); line_px(2, VP, 1'b0, 1'b0);
        gap(); send(VB);
        drain("frameA");
        check("frameA_locked", locked_o, 1);
        check("frameA_err_cnt", parity_err_cnt_o, 0);

        // Frame B: parity and pairing faults, short line, dangling low half
        frame_start();
        send(14'h240); send(14'h02D); expect_pix(8'hB5, 0, 0, 1'b1); e_par++;
        send(14'h340); send(14'h02D); expect_pix(8'hB5, 0, 1, 1'b0);
        send(14'h02D); e_sync++;
        send(w_lo(8'h00, 1'b0)); e_sync++;
        pix(8'h6E, 0, 2, 1'b0, 1'b0);
        pix(8'hC3, 0, 3, 1'b0, 1'b0);
        gap(); line_px(1, VP - 1, 1'b0, 1'b0);
        gap(); e_llen++;
        line_px(2, VP, 1'b0, 1'b0);
        send(w_lo(8'hFF, 1'b0));
        gap(); e_sync++;
        send(VB);
        drain("frameB");
        check("frameB_err_cnt", parity_err_cnt_o, 1);

        // Frame C: overlong line, then Vsync and Hsync rising together
        frame_start();
        line_px(0, VP + 1, 1'b1, 1'b0);
        gap(); e_llen++;
        line_px(1, 2, 1'b0, 1'b0);
        send(VB); e_llen++; e_flen++;
        drain("frameC");

        // Frame D: one line too many
        frame_start();
        for (int l = 0; l <= VL; l++) begin
            line_px(l, VP, l == 0, 1'b0);
            gap();
        end
        send(VB); e_flen++;
        drain("frameD");

        // Reset in the middle of a line
        frame_start();
        line_px(0, 2, 1'b1, 1'b0);
        send(w_lo(8'hAA, 1'b0));
        @(negedge clk);
        data = w_hi(8'hAA);
        rst  = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              {pix_valid_o, sof_o, eol_o, parity_err_o, sync_err_o, line_len_err_o,
               frame_len_err_o, locked_o, pix_o, line_o, col_o}, 0);
        check("midreset_err_cnt", parity_err_cnt_o, 0);
        rst = 1'b0;
        send(w_lo(8'h11, 1'b0)); send(w_hi(8'h11));
        send(HB);
        send(w_lo(8'h22, 1'b0)); send(w_hi(8'h22));
        send(HB);
        drain("after_reset_unlocked");
        check("after_reset_locked", locked_o, 0);
        frame_start();
        line_px(0, VP, 1'b1, 1'b0);
        gap();
        drain("resync");

        // Parity counter saturation: 2^EW + 5 bad words
        line_px(1, (1 << EW) + 5, 1'b0, 1'b1);
        e_par += (1 << EW) + 5;
        gap(); e_llen++;
        drain("saturate");
        check("saturate_err_cnt", parity_err_cnt_o, (1 << EW) - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
